// File: rtl/uart_mem_bridge.sv
// Byte-command bridge from a UART byte stream to a simple synchronous memory port.
// Commands: 'W' AH AL D (reply 'K') and 'R' AH AL (reply data); anything else replies '?'.
module uart_mem_bridge #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_out,
  output logic              rx_en,
  output logic [7:0]        tx_in,
  output logic              tx_en,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_err
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       OP_WRITE = 8'h57;
  localparam logic [7:0]       OP_READ  = 8'h52;
  localparam logic [7:0]       RSP_ACK  = 8'h4B;
  localparam logic [7:0]       RSP_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_D, WRITE, READ, READ_WAIT, SEND, SEND_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_q, tx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              send_first_q, send_first_d;
  logic [15:0]       addr_full;

  // The high byte is staged separately so a timed-out command never disturbs mem_addr.
  assign addr_full = {addr_hi_q, rx_out};

  assign tx_in     = tx_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    addr_hi_d    = addr_hi_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tx_d         = tx_q;
    timer_d      = '0;
    send_first_d = 1'b0;
    rx_en        = 1'b0;
    tx_en        = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    cmd_err      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          rx_en = 1'b1;
          if (rx_valid) begin
            if (rx_out == OP_WRITE || rx_out == OP_READ) begin
              is_wr_d = (rx_out == OP_WRITE);
              state_d = GET_AH;
            end else begin
              cmd_err = 1'b1;
              tx_d    = RSP_ERR;
              state_d = SEND;
            end
          end
        end
        GET_AH, GET_AL, GET_D: begin
          rx_en = 1'b1;
          if (rx_valid) begin
            case (state_q)
              GET_AH: begin
                addr_hi_d = rx_out;
                state_d   = GET_AL;
              end
              GET_AL: begin
                addr_d  = ADDR_W'(addr_full);
                state_d = is_wr_q ? GET_D : READ;
              end
              default: begin
                wdata_d = rx_out;
                state_d = WRITE;
              end
            endcase
          end else if (timer_q == TMR_LAST) begin
            cmd_err = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WRITE: begin
          mem_we  = 1'b1;
          tx_d    = RSP_ACK;
          state_d = SEND;
        end
        READ: begin
          mem_re  = 1'b1;
          state_d = READ_WAIT;
        end
        READ_WAIT: begin
          tx_d    = mem_rdata;
          state_d = SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en        = 1'b1;
            send_first_d = 1'b1;
            state_d      = SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          // tx_busy only rises the cycle after tx_en, so the first cycle here is ignored.
          if (!send_first_q && !tx_busy) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      addr_hi_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_q         <= '0;
      timer_q      <= '0;
      send_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      addr_hi_q    <= addr_hi_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tx_q         <= tx_d;
      timer_q      <= timer_d;
      send_first_q <= send_first_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge with a small UART transmitter
// and single-cycle-latency memory model.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_out = 8'h00;
  logic        rx_en;
  logic [7:0]  tx_in;
  logic        tx_en;
  logic        tx_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cmd_err;

  logic        force_busy = 1'b0;
  logic [7:0]  rd_value = 8'h00;
  int          busy_cnt = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

  int cyc = 0;
  int we_cnt = 0, re_cnt = 0, tx_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int we_cyc = 0, re_cyc = 0, tx_cyc = 0, err_cyc = 0, acc_cyc = 0;
  logic [15:0] we_addr = 0, re_addr = 0;
  logic [7:0]  we_data = 0, tx_byte = 0, hold_byte = 0;
  logic        holding = 1'b0;
  int          hold_viol = 0, overlap = 0;

  uart_mem_bridge #(
    .ADDR_W        (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_out   (rx_out),
    .rx_en    (rx_en),
    .tx_in    (tx_in),
    .tx_en    (tx_en),
    .tx_busy  (tx_busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for 4 cycles starting the cycle after tx_en, optionally held busy.
  assign tx_busy = force_busy | (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_en) busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    mem_rdata <= mem_re ? rd_value : 8'hEE;
  end

  // Event recorder sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_cnt <= we_cnt + 1; we_cyc <= cyc; we_addr <= mem_addr; we_data <= mem_wdata;
    end
    if (mem_re) begin
      re_cnt <= re_cnt + 1; re_cyc <= cyc; re_addr <= mem_addr;
    end
    if (tx_en) begin
      tx_cnt <= tx_cnt + 1; tx_cyc <= cyc; tx_byte <= tx_in;
    end
    if (cmd_err) begin
      err_cnt <= err_cnt + 1; err_cyc <= cyc;
    end
    if (rx_valid && rx_en) begin
      acc_cnt <= acc_cnt + 1; acc_cyc <= cyc;
    end
    if (mem_we && mem_re) overlap <= overlap + 1;
    if (holding && tx_in !== hold_byte) hold_viol <= hold_viol + 1;
    if (tx_en) begin
      holding <= 1'b1; hold_byte <= tx_in;
    end else if (holding && !tx_busy) begin
      holding <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_out   = b;
    n = 0;
    @(negedge clk);
    while (!rx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (rx_en !== 1'b1) $display("FAIL send_byte_%02h rx_en never rose: got=%b exp=1", b, rx_en);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    total_cnt++; if (rx_en !== 1'b0) $display("FAIL rst_rx_en got=%b exp=0", rx_en); else pass_cnt++;
    total_cnt++; if (tx_en !== 1'b0) $display("FAIL rst_tx_en got=%b exp=0", tx_en); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_re !== 1'b0) $display("FAIL rst_mem_re got=%b exp=0", mem_re); else pass_cnt++;
    total_cnt++; if (cmd_err !== 1'b0) $display("FAIL rst_cmd_err got=%b exp=0", cmd_err); else pass_cnt++;
    total_cnt++; if (tx_in !== 8'h00) $display("FAIL rst_tx_in got=%h exp=00", tx_in); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0000) $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 8'h00) $display("FAIL rst_mem_wdata got=%h exp=00", mem_wdata); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (rx_en !== 1'b1) $display("FAIL rst_release_rx_en got=%b exp=1", rx_en); else pass_cnt++;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_write;
    int we0, re0, tx0, err0, a;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    a = acc_cyc;
    tick(12);
    total_cnt++; if (we_cnt - we0 !== 1) $display("FAIL wr_we_count got=%0d exp=1", we_cnt - we0); else pass_cnt++;
    total_cnt++; if (we_addr !== 16'h1234) $display("FAIL wr_addr got=%h exp=1234", we_addr); else pass_cnt++;
    total_cnt++; if (we_data !== 8'hA5) $display("FAIL wr_data got=%h exp=a5", we_data); else pass_cnt++;
    total_cnt++; if (we_cyc - a !== 1) $display("FAIL wr_we_latency got=%0d exp=1", we_cyc - a); else pass_cnt++;
    total_cnt++; if (tx_cnt - tx0 !== 1) $display("FAIL wr_tx_count got=%0d exp=1", tx_cnt - tx0); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h4B) $display("FAIL wr_tx_byte got=%h exp=4b", tx_byte); else pass_cnt++;
    total_cnt++; if (tx_cyc - a !== 2) $display("FAIL wr_tx_latency got=%0d exp=2", tx_cyc - a); else pass_cnt++;
    total_cnt++; if (re_cnt !== re0) $display("FAIL wr_no_re got=%0d exp=%0d", re_cnt, re0); else pass_cnt++;
    total_cnt++; if (err_cnt !== err0) $display("FAIL wr_no_err got=%0d exp=%0d", err_cnt, err0); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h1234) $display("FAIL wr_addr_hold got=%h exp=1234", mem_addr); else pass_cnt++;
    $display("write: 57 12 34 a5 -> we addr=%h data=%h reply=%h", we_addr, we_data, tx_byte);
  endtask

  task automatic test_read;
    int we0, re0, tx0, a;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
    rd_value = 8'h5C;
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    a = acc_cyc;
    tick(12);
    total_cnt++; if (re_cnt - re0 !== 1) $display("FAIL rd_re_count got=%0d exp=1", re_cnt - re0); else pass_cnt++;
    total_cnt++; if (re_addr !== 16'h1234) $display("FAIL rd_addr got=%h exp=1234", re_addr); else pass_cnt++;
    total_cnt++; if (re_cyc - a !== 1) $display("FAIL rd_re_latency got=%0d exp=1", re_cyc - a); else pass_cnt++;
    total_cnt++; if (tx_cnt - tx0 !== 1) $display("FAIL rd_tx_count got=%0d exp=1", tx_cnt - tx0); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h5C) $display("FAIL rd_tx_byte got=%h exp=5c", tx_byte); else pass_cnt++;
    total_cnt++; if (tx_cyc - a !== 3) $display("FAIL rd_tx_latency got=%0d exp=3", tx_cyc - a); else pass_cnt++;
    total_cnt++; if (we_cnt !== we0) $display("FAIL rd_no_we got=%0d exp=%0d", we_cnt, we0); else pass_cnt++;
    $display("read: 52 12 34 -> re addr=%h reply=%h", re_addr, tx_byte);
  endtask

  task automatic test_unknown;
    int we0, re0, tx0, err0, a;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'h41);
    a = acc_cyc;
    tick(12);
    total_cnt++; if (err_cnt - err0 !== 1) $display("FAIL unk_err_count got=%0d exp=1", err_cnt - err0); else pass_cnt++;
    total_cnt++; if (err_cyc < a || err_cyc > a + 1) $display("FAIL unk_err_timing got=%0d exp=%0d..%0d", err_cyc, a, a + 1); else pass_cnt++;
    total_cnt++; if (tx_cnt - tx0 !== 1) $display("FAIL unk_tx_count got=%0d exp=1", tx_cnt - tx0); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h3F) $display("FAIL unk_tx_byte got=%h exp=3f", tx_byte); else pass_cnt++;
    total_cnt++; if (we_cnt !== we0 || re_cnt !== re0) $display("FAIL unk_no_mem got=%0d/%0d exp=%0d/%0d", we_cnt, re_cnt, we0, re0); else pass_cnt++;
    total_cnt++; if (rx_en !== 1'b1) $display("FAIL unk_rx_en_back got=%b exp=1", rx_en); else pass_cnt++;
    $display("unknown: 41 -> cmd_err reply=%h", tx_byte);
  endtask

  task automatic test_timeout;
    int we0, re0, tx0, err0, a;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'h57); send_byte(8'h12);
    a = acc_cyc;
    tick(10);
    total_cnt++; if (err_cnt !== err0) $display("FAIL to_early_err got=%0d exp=%0d", err_cnt, err0); else pass_cnt++;
    tick(15);
    total_cnt++; if (err_cnt - err0 !== 1) $display("FAIL to_err_count got=%0d exp=1", err_cnt - err0); else pass_cnt++;
    total_cnt++; if (err_cyc - a < 16 || err_cyc - a > 17) $display("FAIL to_err_delay got=%0d exp=16..17", err_cyc - a); else pass_cnt++;
    total_cnt++; if (tx_cnt !== tx0) $display("FAIL to_no_tx got=%0d exp=%0d", tx_cnt, tx0); else pass_cnt++;
    total_cnt++; if (we_cnt !== we0 || re_cnt !== re0) $display("FAIL to_no_mem got=%0d/%0d exp=%0d/%0d", we_cnt, re_cnt, we0, re0); else pass_cnt++;
    total_cnt++; if (rx_en !== 1'b1) $display("FAIL to_idle_rx_en got=%b exp=1", rx_en); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h1234) $display("FAIL to_addr_hold got=%h exp=1234", mem_addr); else pass_cnt++;
    rd_value = 8'h77;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    tick(12);
    total_cnt++; if (re_cnt - re0 !== 1) $display("FAIL to_rd_re_count got=%0d exp=1", re_cnt - re0); else pass_cnt++;
    total_cnt++; if (re_addr !== 16'h0001) $display("FAIL to_rd_addr got=%h exp=0001", re_addr); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h77) $display("FAIL to_rd_tx_byte got=%h exp=77", tx_byte); else pass_cnt++;
    $display("timeout: 57 12 <silence> -> cmd_err after %0d cycles, then read reply=%h", err_cyc - a, tx_byte);
  endtask

  task automatic test_backpressure;
    int tx0, acc0, err0, rel;
    rd_value = 8'h3C;
    force_busy = 1'b1;
    tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
    acc0 = acc_cnt;
    rx_valid = 1'b1;
    rx_out   = 8'h41;
    tick(48);
    total_cnt++; if (acc_cnt !== acc0) $display("FAIL bp_no_consume got=%0d exp=%0d", acc_cnt, acc0); else pass_cnt++;
    total_cnt++; if (tx_cnt !== tx0) $display("FAIL bp_tx_held got=%0d exp=%0d", tx_cnt, tx0); else pass_cnt++;
    rx_valid = 1'b0;
    force_busy = 1'b0;
    rel = cyc;
    tick(12);
    total_cnt++; if (tx_cnt - tx0 !== 1) $display("FAIL bp_tx_count got=%0d exp=1", tx_cnt - tx0); else pass_cnt++;
    total_cnt++; if (tx_cyc < rel) $display("FAIL bp_tx_after_release got=%0d exp>=%0d", tx_cyc, rel); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h3C) $display("FAIL bp_tx_byte got=%h exp=3c", tx_byte); else pass_cnt++;
    total_cnt++; if (err_cnt !== err0) $display("FAIL bp_no_err got=%0d exp=%0d", err_cnt, err0); else pass_cnt++;
    $display("backpressure: reply=%h sent at cycle %0d, busy released at %0d", tx_byte, tx_cyc, rel);
  endtask

  task automatic test_reset_mid;
    int we0, tx0, err0;
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
    we0 = we_cnt; tx0 = tx_cnt; err0 = err_cnt;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (rx_en !== 1'b0) $display("FAIL mid_rst_rx_en got=%b exp=0", rx_en); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || tx_en !== 1'b0) $display("FAIL mid_post_strobe got=%b%b%b exp=000", mem_we, mem_re, tx_en); else pass_cnt++;
    total_cnt++; if (rx_en !== 1'b1) $display("FAIL mid_post_rx_en got=%b exp=1", rx_en); else pass_cnt++;
    total_cnt++; if (mem_addr !== 16'h0000) $display("FAIL mid_addr_cleared got=%h exp=0000", mem_addr); else pass_cnt++;
    @(posedge clk); #1;
    send_byte(8'hA5);
    tick(12);
    total_cnt++; if (we_cnt !== we0) $display("FAIL mid_no_we got=%0d exp=%0d", we_cnt, we0); else pass_cnt++;
    total_cnt++; if (err_cnt - err0 !== 1) $display("FAIL mid_err_count got=%0d exp=1", err_cnt - err0); else pass_cnt++;
    total_cnt++; if (tx_cnt - tx0 !== 1 || tx_byte !== 8'h3F) $display("FAIL mid_reply got=%0d/%h exp=1/3f", tx_cnt - tx0, tx_byte); else pass_cnt++;
    $display("reset_mid: 57 12 34 <reset> a5 -> reply=%h", tx_byte);
  endtask

  task automatic test_back_to_back;
    int we0, re0, tx0;
    we0 = we_cnt; re0 = re_cnt; tx0 = tx_cnt;
    rd_value = 8'h99;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h99);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    tick(12);
    total_cnt++; if (we_cnt - we0 !== 1 || we_addr !== 16'h0010) $display("FAIL b2b_write got=%0d@%h exp=1@0010", we_cnt - we0, we_addr); else pass_cnt++;
    total_cnt++; if (re_cnt - re0 !== 1 || re_addr !== 16'h0010) $display("FAIL b2b_read got=%0d@%h exp=1@0010", re_cnt - re0, re_addr); else pass_cnt++;
    total_cnt++; if (tx_cnt - tx0 !== 2) $display("FAIL b2b_tx_count got=%0d exp=2", tx_cnt - tx0); else pass_cnt++;
    total_cnt++; if (tx_byte !== 8'h99) $display("FAIL b2b_last_reply got=%h exp=99", tx_byte); else pass_cnt++;
    $display("back_to_back: write then read 0010 -> reply=%h", tx_byte);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    total_cnt++; if (overlap !== 0) $display("FAIL we_re_overlap got=%0d exp=0", overlap); else pass_cnt++;
    total_cnt++; if (hold_viol !== 0) $display("FAIL tx_in_hold got=%0d exp=0", hold_viol); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width; the two address bytes are sent big-endian and truncated to ADDR_W.
REQ-002 Parameter TIMEOUT_CYCLES, default 5_000_000, maximum idle clk cycles between bytes of one command.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  receive byte available on rx_out.
REQ-006 rx_out  input  8  received byte.
REQ-007 rx_en  output  1  bridge ready; a byte is consumed in any cycle with rx_valid && rx_en.
REQ-008 tx_in  output  8  byte to transmit; held stable from the tx_en cycle until tx_busy falls.
REQ-009 tx_en  output  1  one-cycle transmit-start pulse.
REQ-010 tx_busy  input  1  transmitter busy; contract: rises the cycle after tx_en and stays high until the byte completes.
REQ-011 mem_addr  output  ADDR_W  memory address.
REQ-012 mem_wdata  output  8  write data.
REQ-013 mem_we  output  1  one-cycle write strobe.
REQ-014 mem_re  output  1  one-cycle read strobe; mem_rdata is valid exactly one cycle later.
REQ-015 mem_rdata  input  8  read data.
REQ-016 cmd_err  output  1  one-cycle pulse on unknown command or timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, GET_AH, GET_AL, GET_D, WRITE, READ, READ_WAIT, SEND and SEND_WAIT.
REQ-018 rx_en SHALL be 1 in IDLE, GET_AH, GET_AL and GET_D, and 0 in all other states.
REQ-019 In IDLE, an accepted byte 0x57 ('W') or 0x52 ('R') SHALL be latched as the opcode and move the FSM to GET_AH.
REQ-020 In IDLE, any other accepted byte SHALL pulse cmd_err, load tx_in=0x3F and move to SEND on the next cycle.
REQ-021 GET_AH SHALL latch the address high byte; GET_AL SHALL latch the low byte, then go to GET_D for 'W' or to READ for 'R'.
REQ-022 GET_D SHALL latch mem_wdata and go to WRITE.
REQ-023 WRITE SHALL assert mem_we for exactly one cycle, load tx_in=0x4B ('K') and go to SEND.
REQ-024 READ SHALL assert mem_re for one cycle; READ_WAIT SHALL capture mem_rdata into tx_in; then the FSM goes to SEND.
REQ-025 SEND SHALL wait while tx_busy=1, then pulse tx_en for one cycle and go to SEND_WAIT.
REQ-026 SEND_WAIT SHALL ignore tx_busy in its first cycle, then return to IDLE in the first cycle with tx_busy=0.
REQ-027 Write latency: last data byte accepted in cycle N -> mem_we in N+1 -> tx_en in N+2 when tx_busy=0.
REQ-028 Read latency: low address byte accepted in cycle N -> mem_re in N+1 -> tx_en in N+3 when tx_busy=0.
REQ-029 Inter-byte timer:
- cleared on every accepted byte and in IDLE;
- in any GET_* state, reaching TIMEOUT_CYCLES SHALL pulse cmd_err and return to IDLE;
- no response byte is sent and no memory access is made.
REQ-030 A byte with rx_valid=1 while rx_en=0 SHALL NOT be consumed, latched or counted.
REQ-031 mem_we and mem_re SHALL never be high in the same cycle; mem_addr and mem_wdata SHALL hold their values between commands.

Reset
REQ-032 While reset=1: FSM=IDLE, and tx_en, mem_we, mem_re, cmd_err, tx_in, mem_addr, mem_wdata and the timer all =0; rx_en=0.
REQ-033 Reset SHALL take effect in any state, including mid-command and mid-SEND_WAIT; a partial command is discarded and no strobe is issued in the cycle after release.
REQ-034 rx_en SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Write: bytes 57 12 34 A5 -> one mem_we with mem_addr=0x1234, mem_wdata=0xA5; tx_in=0x4B with a single tx_en pulse two cycles after the A5 accept.
REQ-036 Read: bytes 52 12 34 with mem_rdata=0x5C -> one mem_re at mem_addr=0x1234; tx_in=0x5C, tx_en three cycles after the 34 accept.
REQ-037 Unknown command: byte 0x41 -> cmd_err pulse, tx_in=0x3F sent, no mem_we/mem_re; rx_en returns to 1 after tx_busy falls.
REQ-038 Timeout: TIMEOUT_CYCLES=16, bytes 57 12 then silence -> cmd_err pulse after 16 cycles, FSM back in IDLE, no tx_en; a following 52 00 01 completes a normal read.
REQ-039 Backpressure: tx_busy held high for 50 cycles when SEND is entered -> tx_en is delayed until tx_busy falls, and rx_valid pulses during SEND/SEND_WAIT are not consumed.
REQ-040 Reset mid-command: 57 12 34, then reset for 1 cycle, then A5 -> no mem_we; A5 is treated as an unknown command and 0x3F is returned.
